// File: rtl/spi_shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine_pkg
// Description : Shared constants and state encoding for the SPI shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_shift_engine_pkg;

    // Default maximum character length and the matching length-field width
    localparam int SPI_MAX_CHAR_DFLT      = 32;
    localparam int SPI_CHAR_LEN_BITS_DFLT = $clog2(SPI_MAX_CHAR_DFLT);

    // Transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } spi_state_t;

endpackage : spi_shift_engine_pkg
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : SPI data shifter. Presents transmit bits on o_mosi and
//               assembles received bits from i_miso, driven by SCLK edge
//               strobes from an external clock generator.
//               Optional feature macro: SPI_LSB_FIRST_EN (adds i_lsb for
//               per-transfer LSB-first ordering; default is MSB-first only).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int SPI_MAX_CHAR      = SPI_MAX_CHAR_DFLT,
    parameter int SPI_CHAR_LEN_BITS = $clog2(SPI_MAX_CHAR)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_go,
    input  logic [SPI_CHAR_LEN_BITS-1:0] i_char_len,
    input  logic                         i_tx_negedge,
    input  logic                         i_rx_negedge,
`ifdef SPI_LSB_FIRST_EN
    input  logic                         i_lsb,
`endif
    input  logic                         i_pos_edge,
    input  logic                         i_neg_edge,
    input  logic [SPI_MAX_CHAR-1:0]      i_tx_data,
    input  logic                         i_miso,
    output logic                         o_tx_start,
    output logic                         o_last_clk,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [SPI_MAX_CHAR-1:0]      o_rx_data,
    output logic                         o_mosi
);

    localparam int CLB = SPI_CHAR_LEN_BITS;

    // Counters carry one extra bit so a full SPI_MAX_CHAR length compares cleanly
    localparam logic [CLB:0]   c_cnt_one = {{CLB{1'b0}}, 1'b1};
    localparam logic [CLB:0]   c_max_len = {1'b1, {CLB{1'b0}}};
    localparam logic [CLB-1:0] c_idx_one = {{(CLB-1){1'b0}}, 1'b1};

    spi_state_t              r_state;
    logic [CLB:0]            r_len;
    logic [CLB-1:0]          r_last_idx;
    logic                    r_tx_neg;
    logic                    r_rx_neg;
    logic                    r_lsb;
    logic [SPI_MAX_CHAR-1:0] r_tx_word;
    logic [SPI_MAX_CHAR-1:0] r_rx;
    logic [CLB:0]            r_tx_cnt;
    logic [CLB:0]            r_rx_cnt;
    logic                    r_mosi;
    logic                    r_tx_start;
    logic                    r_last_clk;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_lsb_in;
    logic [CLB:0]            w_go_len;
    logic [CLB-1:0]          w_go_last_idx;
    logic                    w_go_first;
    logic                    w_tx_edge;
    logic                    w_rx_edge;
    logic [CLB:0]            w_rx_cnt_nxt;
    logic [CLB-1:0]          w_rx_idx;
    logic [CLB-1:0]          w_tx_idx;
    logic                    w_tx_adv;
    logic                    w_rx_last;

`ifdef SPI_LSB_FIRST_EN
    assign w_lsb_in = i_lsb;
`else
    assign w_lsb_in = 1'b0;
`endif

    // Length 0 encodes the maximum; N-1 wraps naturally in CLB bits
    assign w_go_len      = (i_char_len == '0) ? c_max_len : {1'b0, i_char_len};
    assign w_go_last_idx = i_char_len - c_idx_one;
    assign w_go_first    = w_lsb_in ? i_tx_data[0] : i_tx_data[w_go_last_idx];

    // Edge select: two-input mux per direction, chosen at transfer start
    assign w_tx_edge = r_tx_neg ? i_neg_edge : i_pos_edge;
    assign w_rx_edge = r_rx_neg ? i_neg_edge : i_pos_edge;

    // Receive count after this cycle's rx edge; tx advance sees this value
    assign w_rx_cnt_nxt = w_rx_edge ? (r_rx_cnt + c_cnt_one) : r_rx_cnt;
    assign w_rx_last    = w_rx_edge && (w_rx_cnt_nxt == r_len);

    // Bit positions for the current receive bit and the next transmit bit
    assign w_rx_idx = r_lsb ? r_rx_cnt[CLB-1:0]
                            : (r_last_idx - r_rx_cnt[CLB-1:0]);
    assign w_tx_idx = r_lsb ? (r_tx_cnt[CLB-1:0] + c_idx_one)
                            : (r_last_idx - r_tx_cnt[CLB-1:0] - c_idx_one);

    // MOSI only moves once the first bit has been sampled and bits remain
    assign w_tx_adv = w_tx_edge && (w_rx_cnt_nxt != '0) &&
                      (r_tx_cnt < (r_len - c_cnt_one));

    // Transfer sequencer with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_last_idx <= '0;
            r_tx_neg   <= 1'b0;
            r_rx_neg   <= 1'b0;
            r_lsb      <= 1'b0;
            r_tx_word  <= '0;
            r_rx       <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_mosi     <= 1'b0;
            r_tx_start <= 1'b0;
            r_last_clk <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_state    <= ST_SHIFT;
                        r_len      <= w_go_len;
                        r_last_idx <= w_go_last_idx;
                        r_tx_neg   <= i_tx_negedge;
                        r_rx_neg   <= i_rx_negedge;
                        r_lsb      <= w_lsb_in;
                        r_tx_word  <= i_tx_data;
                        r_rx       <= '0;
                        r_tx_cnt   <= '0;
                        r_rx_cnt   <= '0;
                        r_mosi     <= w_go_first;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_last_clk <= (w_go_len == c_cnt_one);
                    end
                end
                ST_SHIFT: begin
                    if (w_rx_edge) begin
                        r_rx[w_rx_idx] <= i_miso;
                        r_rx_cnt       <= w_rx_cnt_nxt;
                    end
                    if (w_tx_adv) begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_one;
                        r_mosi   <= r_tx_word[w_tx_idx];
                    end
                    if (w_rx_last) begin
                        r_state    <= ST_FINISH;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_last_clk <= 1'b0;
                    end else begin
                        r_last_clk <= (w_rx_cnt_nxt == (r_len - c_cnt_one));
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_last_clk = r_last_clk;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_rx_data  = r_rx;
    assign o_mosi     = r_mosi;

endmodule : spi_shift_engine
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Directed self-checking bench for spi_shift_engine.
//               Optional feature macro: SPI_LSB_FIRST_EN (adds LSB-first case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;

    logic        clk;
    logic        rst;
    logic        i_go;
    logic [4:0]  i_char_len;
    logic        i_tx_negedge;
    logic        i_rx_negedge;
    logic        r_lsb;
    logic        i_pos_edge;
    logic        i_neg_edge;
    logic [31:0] i_tx_data;
    logic        o_tx_start;
    logic        o_last_clk;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rx_data;
    logic        o_mosi;
    logic        loop_en;
    logic        miso_fix;
    logic        w_miso;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    assign w_miso = loop_en ? o_mosi : miso_fix;

    spi_shift_engine #(
        .SPI_MAX_CHAR      (32),
        .SPI_CHAR_LEN_BITS (5)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_go         (i_go),
        .i_char_len   (i_char_len),
        .i_tx_negedge (i_tx_negedge),
        .i_rx_negedge (i_rx_negedge),
`ifdef SPI_LSB_FIRST_EN
        .i_lsb        (r_lsb),
`endif
        .i_pos_edge   (i_pos_edge),
        .i_neg_edge   (i_neg_edge),
        .i_tx_data    (i_tx_data),
        .i_miso       (w_miso),
        .o_tx_start   (o_tx_start),
        .o_last_clk   (o_last_clk),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_rx_data    (o_rx_data),
        .o_mosi       (o_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion pulses
    always @(negedge clk) if (o_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive strobes for one clock, then return at the next falling edge
    task automatic step(input logic go, input logic pe, input logic ne);
        i_go       = go;
        i_pos_edge = pe;
        i_neg_edge = ne;
        @(negedge clk);
        i_go       = 1'b0;
        i_pos_edge = 1'b0;
        i_neg_edge = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/tx_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "/last_clk"}, 32'(o_last_clk), 32'd0);
        chk({tag, "/busy"},     32'(o_busy),     32'd0);
        chk({tag, "/done"},     32'(o_done),     32'd0);
        chk({tag, "/mosi"},     32'(o_mosi),     32'd0);
        chk({tag, "/rx_data"},  o_rx_data,       32'd0);
    endtask

    task automatic run_xfer(input string tag, input logic [4:0] code, input int n,
                            input logic [31:0] tx, input logic txneg, input logic rxneg,
                            input logic lsb, input logic both, input logic spam,
                            input logic loop, input logic [31:0] exp_rx);
        int d0;
        int idx;
        i_char_len   = code;
        i_tx_data    = tx;
        i_tx_negedge = txneg;
        i_rx_negedge = rxneg;
        r_lsb        = lsb;
        loop_en      = loop;
        miso_fix     = 1'b1;
        d0           = done_cnt;
        step(1'b1, 1'b0, 1'b0);
        chk({tag, "/start_busy"},     32'(o_busy),     32'd1);
        chk({tag, "/start_tx_start"}, 32'(o_tx_start), 32'd1);
        chk({tag, "/start_last_clk"}, 32'(o_last_clk), 32'(n == 1));
        if (spam) begin
            i_char_len   = ~code;
            i_tx_data    = ~tx;
            i_tx_negedge = ~txneg;
            i_rx_negedge = ~rxneg;
        end
        for (int i = 0; i < n; i++) begin
            idx = lsb ? i : (n - 1 - i);
            if (both) begin
                chk($sformatf("%s/mosi%0d", tag, i), 32'(o_mosi), 32'(tx[idx]));
                chk($sformatf("%s/last%0d", tag, i), 32'(o_last_clk), 32'(i == n - 1));
                step(spam, 1'b1, 1'b1);
            end else if (rxneg) begin
                step(spam, 1'b1, 1'b0);
                chk($sformatf("%s/mosi%0d", tag, i), 32'(o_mosi), 32'(tx[idx]));
                chk($sformatf("%s/last%0d", tag, i), 32'(o_last_clk), 32'(i == n - 1));
                step(spam, 1'b0, 1'b1);
            end else begin
                chk($sformatf("%s/mosi%0d", tag, i), 32'(o_mosi), 32'(tx[idx]));
                chk($sformatf("%s/last%0d", tag, i), 32'(o_last_clk), 32'(i == n - 1));
                step(spam, 1'b1, 1'b0);
            end
            if (i == n - 1) begin
                chk({tag, "/fin_done"}, 32'(o_done), 32'd1);
                chk({tag, "/fin_busy"}, 32'(o_busy), 32'd0);
            end
            if (!both && !rxneg) step(spam, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk({tag, "/end_done"},  32'(o_done), 32'd0);
        chk({tag, "/end_busy"},  32'(o_busy), 32'd0);
        chk({tag, "/rx_data"},   o_rx_data,   exp_rx);
        chk({tag, "/done_cnt"},  32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst          = 1'b1;
        i_go         = 1'b0;
        i_char_len   = '0;
        i_tx_negedge = 1'b0;
        i_rx_negedge = 1'b0;
        r_lsb        = 1'b0;
        i_pos_edge   = 1'b0;
        i_neg_edge   = 1'b0;
        i_tx_data    = '0;
        loop_en      = 1'b1;
        miso_fix     = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // 8-bit MSB-first loopback: MOSI 1,0,1,0,0,1,0,1
        run_xfer("n8_a5", 5'd8, 8, 32'h0000_00A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00A5);

        // Full 32-bit word, tx on rising strobe, rx on falling strobe
        run_xfer("n32", 5'd0, 32, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Repeated go while busy plus simultaneous strobes; controls scrambled mid-transfer
        run_xfer("spam", 5'd4, 4, 32'h0000_0009, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0009);

        // Reset after three of eight bits
        i_char_len   = 5'd8;
        i_tx_data    = 32'h0000_00A5;
        i_tx_negedge = 1'b1;
        i_rx_negedge = 1'b0;
        r_lsb        = 1'b0;
        loop_en      = 1'b1;
        d0           = done_cnt;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("mid_rx_partial", o_rx_data, 32'h0000_00A0);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        chk_all_zero("rst_next");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1);
        end
        chk("rst_no_done",  32'(done_cnt - d0), 32'd0);
        chk("rst_idle_busy", 32'(o_busy), 32'd0);
        run_xfer("after_rst", 5'd8, 8, 32'h0000_005A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_005A);

        // Single-bit transfer, MISO tied high: only bit 0 may be set
        run_xfer("n1", 5'd1, 1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001);

`ifdef SPI_LSB_FIRST_EN
        // LSB-first, 4 bits of 0x3 with MISO tied high: MOSI 1,1,0,0
        run_xfer("lsb4", 5'd4, 4, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000F);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spi_shift_engine
`default_nettype wire
